// File: rtl/sysio_bus_arb.sv
// Two-master round-robin arbiter for the sysio peripheral bus. It serialises whole
// AW+W or AR/R transactions and recovers hung reads with an error response.
module sysio_bus_arb #(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        DATA_W   = 32,
  parameter logic [7:0]         TIMEOUT  = 8'd255,
  parameter logic [DATA_W-1:0]  ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m0_awaddr,
  input  logic              m0_awvalid,
  output logic              m0_awready,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [3:0]        m0_wstrb,
  input  logic              m0_wvalid,
  output logic              m0_wready,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic [ADDR_W-1:0] m1_awaddr,
  input  logic              m1_awvalid,
  output logic              m1_awready,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [3:0]        m1_wstrb,
  input  logic              m1_wvalid,
  output logic              m1_wready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [ADDR_W-1:0] s_awaddr,
  output logic              s_awvalid,
  input  logic              s_awready,
  output logic [DATA_W-1:0] s_wdata,
  output logic [3:0]        s_wstrb,
  output logic              s_wvalid,
  input  logic              s_wready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rvalid,
  output logic              s_rready,
  output logic              owner_o,
  output logic              busy_o,
  output logic              tmo_o
);

  typedef enum logic [1:0] {IDLE, XFER, RWAIT, ERESP} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        op_q, op_d;            // 1 = write, 0 = read
  logic        tmo_q, tmo_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        gnt;
  logic [1:0]  wreq, req;
  logic [1:0]  m_awready, m_wready, m_arready, m_rvalid;
  logic [DATA_W-1:0] rdata;
  logic        own_wreq, own_rreq, own_rready;

  assign wreq = {m1_awvalid & m1_wvalid, m0_awvalid & m0_wvalid};
  assign req  = wreq | {m1_arvalid, m0_arvalid};

  assign own_wreq   = owner_q ? wreq[1]    : wreq[0];
  assign own_rreq   = owner_q ? m1_arvalid : m0_arvalid;
  assign own_rready = owner_q ? m1_rready  : m0_rready;

  // Payloads follow the owner unconditionally; only the valids are gated.
  assign s_awaddr = owner_q ? m1_awaddr : m0_awaddr;
  assign s_wdata  = owner_q ? m1_wdata  : m0_wdata;
  assign s_wstrb  = owner_q ? m1_wstrb  : m0_wstrb;
  assign s_araddr = owner_q ? m1_araddr : m0_araddr;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    tmo_d     = 1'b0;
    gnt       = 1'b0;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    m_awready = 2'b00;
    m_wready  = 2'b00;
    m_arready = 2'b00;
    m_rvalid  = 2'b00;
    rdata     = '0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          // On contention the master that did not own the bus last time wins.
          gnt     = (&req) ? ~owner_q : req[1];
          owner_d = gnt;
          op_d    = wreq[gnt];
          state_d = XFER;
        end
      end
      XFER: begin
        if (op_q) begin
          s_awvalid          = own_wreq;
          s_wvalid           = own_wreq;
          m_awready[owner_q] = s_awready;
          m_wready[owner_q]  = s_wready;
          if (!own_wreq || (s_awready && s_wready)) state_d = IDLE;
        end else begin
          s_arvalid          = own_rreq;
          m_arready[owner_q] = s_arready;
          if (own_rreq && s_arready) begin
            cnt_d   = 8'd0;
            state_d = RWAIT;
          end else if (!own_rreq) begin
            state_d = IDLE;
          end
        end
      end
      RWAIT: begin
        m_rvalid[owner_q] = s_rvalid;
        s_rready          = own_rready;
        rdata             = s_rdata;
        if (s_rvalid && own_rready) begin
          state_d = IDLE;
        end else if (!s_rvalid) begin
          cnt_d = cnt_q + 8'd1;
          if ((TIMEOUT != 8'd0) && (cnt_d == TIMEOUT)) begin
            state_d = ERESP;
            tmo_d   = 1'b1;
          end
        end
      end
      ERESP: begin
        // Late slave responses are drained here and never reach the master.
        m_rvalid[owner_q] = 1'b1;
        rdata             = ERR_DATA;
        s_rready          = 1'b1;
        if (own_rready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b1;
      op_q    <= 1'b0;
      cnt_q   <= 8'd0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign m0_awready = m_awready[0];
  assign m1_awready = m_awready[1];
  assign m0_wready  = m_wready[0];
  assign m1_wready  = m_wready[1];
  assign m0_arready = m_arready[0];
  assign m1_arready = m_arready[1];
  assign m0_rvalid  = m_rvalid[0];
  assign m1_rvalid  = m_rvalid[1];
  assign m0_rdata   = rdata;
  assign m1_rdata   = rdata;
  assign owner_o    = owner_q;
  assign busy_o     = (state_q != IDLE);
  assign tmo_o      = tmo_q;

endmodule

// File: tb/tb_sysio_bus_arb.sv
// Scoreboard bench for sysio_bus_arb: two master drivers, a reactive slave,
// and a negedge monitor that checks slave writes and master read returns in order.
module tb_sysio_bus_arb;

  logic        clk, rst_n;
  logic [31:0] m_awaddr[2], m_wdata[2], m_araddr[2];
  logic [3:0]  m_wstrb[2];
  logic [1:0]  m_awvalid, m_wvalid, m_arvalid, m_rready;
  logic        m0_awready, m0_wready, m0_arready, m0_rvalid;
  logic        m1_awready, m1_wready, m1_arready, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  m_awready, m_wready, m_arready, m_rvalid;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic        owner_o, busy_o, tmo_o;

  assign m_awready = {m1_awready, m0_awready};
  assign m_wready  = {m1_wready,  m0_wready};
  assign m_arready = {m1_arready, m0_arready};
  assign m_rvalid  = {m1_rvalid,  m0_rvalid};

  sysio_bus_arb #(.TIMEOUT(8'd4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_awaddr(m_awaddr[0]), .m0_awvalid(m_awvalid[0]), .m0_awready(m0_awready),
    .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_wvalid(m_wvalid[0]), .m0_wready(m0_wready),
    .m0_araddr(m_araddr[0]), .m0_arvalid(m_arvalid[0]), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_rready(m_rready[0]),
    .m1_awaddr(m_awaddr[1]), .m1_awvalid(m_awvalid[1]), .m1_awready(m1_awready),
    .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_wvalid(m_wvalid[1]), .m1_wready(m1_wready),
    .m1_araddr(m_araddr[1]), .m1_arvalid(m_arvalid[1]), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_rready(m_rready[1]),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .owner_o(owner_o), .busy_o(busy_o), .tmo_o(tmo_o)
  );

  typedef struct packed { logic m; logic [31:0] a; logic [31:0] d; } w_t;
  typedef struct packed { logic m; logic [31:0] d; } r_t;

  w_t wq[$];
  r_t rq[$];
  int nchk = 0, nerr = 0, ntmo = 0, cyc = 0, wr_cyc = 0, ar_cyc = 0, rd_lat = 1;
  bit slv_mute = 1'b0;
  logic [31:0] ra;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rdf(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  initial begin clk = 1'b0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end

  // Caller enters at posedge+1; keeps valids up afterwards unless last.
  task automatic mwrite(input int m, input logic [31:0] a, input logic [31:0] d, input bit last);
    int n;
    m_awaddr[m] = a; m_wdata[m] = d; m_wstrb[m] = 4'hf;
    m_awvalid[m] = 1'b1; m_wvalid[m] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(m_awready[m] && m_wready[m]) && n < 40);
    chk("aw_wait", n < 40, 1);
    @(posedge clk); #1;
    if (last) begin m_awvalid[m] = 1'b0; m_wvalid[m] = 1'b0; end
  endtask

  task automatic mread(input int m, input logic [31:0] a);
    int n;
    m_araddr[m] = a; m_arvalid[m] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!m_arready[m] && n < 40);
    chk("ar_wait", n < 40, 1);
    @(posedge clk); #1;
    m_arvalid[m] = 1'b0; m_rready[m] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!m_rvalid[m] && n < 40);
    chk("r_wait", n < 40, 1);
    @(posedge clk); #1;
    m_rready[m] = 1'b0;
  endtask

  // Slave read responder with rd_lat cycles of latency.
  initial begin
    s_rvalid = 1'b0; s_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n && s_arvalid && s_arready && !slv_mute) begin
        int n;
        ra = s_araddr;
        @(posedge clk); #1;
        for (int i = 0; i < rd_lat; i++) begin @(posedge clk); #1; end
        s_rdata = rdf(ra); s_rvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s_rready && n < 40);
        chk("s_rready_wait", n < 40, 1);
        @(posedge clk); #1;
        s_rvalid = 1'b0; s_rdata = '0;
      end
    end
  end

  // Monitor: scoreboard pops plus per-cycle routing invariants.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (tmo_o) ntmo++;
      if (s_awvalid && s_awready && s_wvalid && s_wready) begin
        w_t we;
        wr_cyc = cyc;
        chk("wr_expected", wq.size() > 0, 1);
        if (wq.size() > 0) begin
          we = wq.pop_front();
          chk("wr_owner", owner_o, we.m);
          chk("wr_addr", s_awaddr, we.a);
          chk("wr_data", s_wdata, we.d);
          chk("wr_strb", s_wstrb, 4'hf);
        end
      end
      if (s_arvalid && s_arready) ar_cyc = cyc;
      for (int m = 0; m < 2; m++) begin
        if (m_rvalid[m] && m_rready[m]) begin
          r_t re;
          chk("rd_expected", rq.size() > 0, 1);
          if (rq.size() > 0) begin
            re = rq.pop_front();
            chk("rd_master", m, re.m);
            chk("rd_data", (m == 0) ? m0_rdata : m1_rdata, re.d);
          end
        end
      end
      if (!busy_o) begin
        chk("idle_quiet", {m_awready, m_wready, m_arready, m_rvalid,
                           s_awvalid, s_wvalid, s_arvalid, s_rready}, 0);
      end else begin
        int o;
        o = owner_o ? 0 : 1;
        chk("nonowner_quiet", {m_awready[o], m_wready[o], m_arready[o], m_rvalid[o]}, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0;
    m_awvalid = '0; m_wvalid = '0; m_arvalid = '0; m_rready = '0;
    for (int i = 0; i < 2; i++) begin
      m_awaddr[i] = '0; m_wdata[i] = '0; m_araddr[i] = '0; m_wstrb[i] = '0;
    end
    s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_owner", owner_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_svalid", {s_awvalid, s_wvalid, s_arvalid, s_rready}, 0);
    chk("rst_mready", {m_awready, m_wready, m_arready, m_rvalid}, 0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
    chk("rst_tmo", tmo_o, 0);
    rst_n = 1'b1;

    // Simultaneous reads: M0 first, then M1.
    rd_lat = 2;
    rq.push_back(r_t'{m: 1'b0, d: rdf(32'h0000_0100)});
    rq.push_back(r_t'{m: 1'b1, d: rdf(32'h0000_0180)});
    @(posedge clk); #1;
    fork
      mread(0, 32'h0000_0100);
      mread(1, 32'h0000_0180);
    join
    rd_lat = 1;

    // Single M0 write: one grant cycle, then a one-cycle handshake.
    @(posedge clk); #1;
    wq.push_back(w_t'{m: 1'b0, a: 32'h0000_0104, d: 32'h0000_0055});
    m_awaddr[0] = 32'h0000_0104; m_wdata[0] = 32'h55; m_wstrb[0] = 4'hf;
    m_awvalid[0] = 1'b1; m_wvalid[0] = 1'b1;
    @(negedge clk);
    chk("w1_grant_cycle_rdy", m0_awready, 0);
    chk("w1_grant_cycle_busy", busy_o, 0);
    @(negedge clk);
    chk("w1_awready", m0_awready, 1);
    chk("w1_owner", owner_o, 0);
    chk("w1_s_aw", {s_awvalid, s_wvalid, s_awaddr}, {2'b11, 32'h0000_0104});
    @(posedge clk); #1;
    m_awvalid[0] = 1'b0; m_wvalid[0] = 1'b0;
    @(negedge clk);
    chk("w1_awready_drop", m0_awready, 0);
    chk("w1_back_idle", busy_o, 0);

    // M1 write and read together: write first, read after a fresh grant.
    wq.push_back(w_t'{m: 1'b1, a: 32'h0000_0300, d: 32'h0000_3333});
    rq.push_back(r_t'{m: 1'b1, d: rdf(32'h0000_0304)});
    @(posedge clk); #1;
    fork
      mwrite(1, 32'h0000_0300, 32'h0000_3333, 1'b1);
      mread(1, 32'h0000_0304);
    join
    chk("wbr_gap", ar_cyc - wr_cyc, 2);

    // Continuous writes from both masters: strict 0,1,0,1 alternation.
    for (int i = 0; i < 4; i++) begin
      wq.push_back(w_t'{m: 1'b0, a: 32'h1000 + i * 4, d: 32'hA000 + i});
      wq.push_back(w_t'{m: 1'b1, a: 32'h2000 + i * 4, d: 32'hB000 + i});
    end
    @(posedge clk); #1;
    fork
      begin for (int i = 0; i < 4; i++) mwrite(0, 32'h1000 + i * 4, 32'hA000 + i, i == 3); end
      begin for (int i = 0; i < 4; i++) mwrite(1, 32'h2000 + i * 4, 32'hB000 + i, i == 3); end
    join
    chk("alt_all_written", wq.size(), 0);

    // Owner withdraws its read after the grant: no slave access.
    @(posedge clk); #1;
    m_araddr[0] = 32'h0000_0400; m_arvalid[0] = 1'b1;
    @(posedge clk); #1;
    m_arvalid[0] = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy_o, 1);
    chk("abort_no_ar", s_arvalid, 0);
    @(negedge clk);
    chk("abort_idle", busy_o, 0);

    // Silent slave: timeout after 4 RWAIT cycles, error data, late response swallowed.
    slv_mute = 1'b1;
    @(posedge clk); #1;
    m_araddr[0] = 32'h0000_0200; m_arvalid[0] = 1'b1; m_rready[0] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!m0_arready && n < 40);
    chk("tmo_ar_wait", n < 40, 1);
    @(posedge clk); #1;
    m_arvalid[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("tmo_early", {tmo_o, m0_rvalid}, 0);
    end
    @(negedge clk);
    chk("tmo_pulse", tmo_o, 1);
    chk("tmo_rvalid", m0_rvalid, 1);
    chk("tmo_rdata", m0_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    s_rvalid = 1'b1; s_rdata = 32'h0000_1234;
    @(negedge clk);
    chk("tmo_pulse_end", tmo_o, 0);
    chk("tmo_drain_rready", s_rready, 1);
    chk("tmo_late_hidden", m0_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    s_rvalid = 1'b0; s_rdata = '0;
    rq.push_back(r_t'{m: 1'b0, d: 32'hDEAD_BEEF});
    m_rready[0] = 1'b1;
    @(posedge clk); #1;
    m_rready[0] = 1'b0;
    @(negedge clk);
    chk("tmo_idle", busy_o, 0);
    chk("tmo_count", ntmo, 1);

    // Async reset while M1 waits in RWAIT, then a normal M1 read.
    @(posedge clk); #1;
    m_araddr[1] = 32'h0000_0500; m_arvalid[1] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!m1_arready && n < 40);
    chk("rst_ar_wait", n < 40, 1);
    @(posedge clk); #1;
    m_arvalid[1] = 1'b0; m_rready[1] = 1'b1;
    @(negedge clk);
    chk("rst_pre_busy", busy_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_owner", owner_o, 1);
    chk("rst_mid_outs", {m_rvalid, s_rready, s_arvalid, tmo_o}, 0);
    chk("rst_mid_rdata", m1_rdata, 0);
    @(negedge clk);
    rst_n = 1'b1; m_rready[1] = 1'b0; slv_mute = 1'b0;
    rq.push_back(r_t'{m: 1'b1, d: rdf(32'h0000_0508)});
    @(posedge clk); #1;
    mread(1, 32'h0000_0508);

    repeat (3) @(negedge clk);
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
